sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO that succeeds the fixed 8-deep FIFO in the GCD datapath.
- Supports any depth, including non-power-of-two, with explicit wrap.
- Provides occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous clear.
- Selectable standard (registered-read) or first-word-fall-through (FWFT) output mode.
- Buffers operands/results between GCD producer and consumer stages.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, any integer)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_LEVEL, DEPTH-1, almost_full_o asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty_o asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
clr_i  in  1  synchronous clear: empty FIFO, clear error flags
wr_en_i  in  1  write request
data_i  in  DATA_WIDTH  write data
rd_en_i  in  1  read request
data_o  out  DATA_WIDTH  read data
valid_o  out  1  data_o holds a valid popped (mode 0) or head (mode 1) word
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
count_o  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
almost_full_o  out  1  count >= AF_LEVEL
almost_empty_o  out  1  count <= AE_LEVEL
overflow_o  out  1  sticky: write attempted while full
underflow_o  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_ni low, async): pointers=0, count=0, data_o=0, valid_o=0, overflow_o=0, underflow_o=0. Resulting flags: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0. Memory contents need not be reset.
- Reset mid-operation discards all stored data; first write after release lands in entry 0.
- Write accepted: wr_en_i && !full_o. Stores data_i at wptr. wptr <= (wptr==DEPTH-1) ? 0 : wptr+1.
- Read accepted: rd_en_i && !empty_o. rptr advances with the same wrap rule.
- Pointer width: $clog2(DEPTH). Full/empty derive from count_o, not pointer MSB.
- Count update per cycle: +1 write only, -1 read only, unchanged for both or neither.
- Simultaneous write+read:
  - Not full, not empty: both accepted; count unchanged.
  - When empty: write accepted, read rejected (underflow set).
  - When full: read accepted, write rejected (overflow set). No same-cycle bypass.
- Rejected write when full: data dropped, overflow_o <= 1, held until clr_i or reset.
- Rejected read when empty: no pointer change, underflow_o <= 1, held likewise.
- FWFT=0: on accepted read, data_o <= mem[rptr] and valid_o <= 1 next cycle (1-cycle latency). Cycle with no accepted read: valid_o <= 0 and data_o holds its last value. Read entries are not zeroed.
- FWFT=1: data_o = mem[rptr] combinationally from the registered pointer, valid_o = !empty_o. rd_en_i pops the head; new head is visible next cycle. When empty, data_o is don't-care; the bench checks it only when valid_o=1.
- clr_i: highest priority below reset. Same-cycle wr/rd are ignored. Next cycle: pointers=0, count=0, valid_o=0, both error flags=0. data_o holds in mode 0. No error flag is set in the clear cycle.
- All flags and count_o are registered or derived solely from registered count; no combinational path from wr_en_i/rd_en_i to any output.
- Order preserved strictly: words exit in write order across any number of wraps.

Test Plan:
- DEPTH=5, FWFT=0: write 0x11..0x15 -> full_o=1, count_o=5 after 5th edge. Read 5 -> data_o 0x11..0x15 each one cycle after rd_en_i, valid_o=1 each. Then empty_o=1.
- DEPTH=5 wrap: repeat 3 rounds of 3 writes/3 reads (values 0..8) -> output order 0..8 exact, count_o never exceeds 3, pointers wrap 4->0.
- Full + write + read same cycle (DEPTH=5 full with 0xA0..0xA4, write 0xFF) -> 0xA0 out, 0xFF dropped, count_o=4, overflow_o=1 sticky. Read-on-empty -> underflow_o=1. clr_i -> both flags 0, count_o=0.
- FWFT=1, DEPTH=4: write 0x3C -> next cycle valid_o=1, data_o=0x3C without rd_en_i. Pop -> valid_o=0, empty_o=1.
- AF_LEVEL=3, AE_LEVEL=1, DEPTH=4: fill 0->4 -> almost_empty_o 1,1,0,0,0 and almost_full_o 0,0,0,1,1 at counts 0..4.
- Assert rst_ni low asynchronously mid-clock with count_o=3 -> count_o=0, empty_o=1, data_o=0, valid_o=0 immediately. Next write+read returns the new word only.

Source files
------------

// File: rtl/sync_fifo_param.sv
// ============================================================================
// sync_fifo_param : parametrised synchronous FIFO, any depth, std/FWFT output
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         wr_en_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         rd_en_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full, empty, wr_acc, rd_acc;

  always_comb begin
    full        = (count_q == CNT_FULL);
    empty       = (count_q == '0);
    wr_acc      = wr_en_i && !full && !clr_i;
    rd_acc      = rd_en_i && !empty && !clr_i;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_i) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // Explicit wrap keeps non-power-of-two depths correct
      if (wr_acc) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
      if (rd_acc) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wr_en_i && full)  overflow_d  = 1'b1;
      if (rd_en_i && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wptr_q] <= data_i;
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= CNT_AF);
  assign almost_empty_o = (count_q <= CNT_AE);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_o  = mem_q[rptr_q];
      assign valid_o = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  valid_q, valid_d;

      // Popped word is held after valid drops; clear leaves it untouched
      always_comb begin
        data_d  = rd_acc ? mem_q[rptr_q] : data_q;
        valid_d = rd_acc;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
        end
      end

      assign data_o  = data_q;
      assign valid_o = valid_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// tb_sync_fifo_param : scoreboard bench, standard lane (DEPTH 5) + FWFT lane (DEPTH 4)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  bit         checking = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  logic       wr_en [2];
  logic       rd_en [2];
  logic       clr   [2];
  logic [7:0] din   [2];
  logic [7:0] dout  [2];
  logic       valid [2];
  logic       full  [2];
  logic       empty [2];
  logic [2:0] cnt   [2];
  logic       afull [2];
  logic       aempty[2];
  logic       ovf_o [2];
  logic       unf_o [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int lane, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", nm, lane, act, exp, $time);
    end
  endtask

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int D  = (g == 0) ? 5 : 4;
      localparam int FW = (g == 0) ? 0 : 1;
      localparam int AF = (g == 0) ? 4 : 3;
      localparam int AE = 1;

      sync_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(D), .FWFT(FW), .AF_LEVEL(AF), .AE_LEVEL(AE)
      ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[g]),
        .wr_en_i(wr_en[g]), .data_i(din[g]), .rd_en_i(rd_en[g]),
        .data_o(dout[g]), .valid_o(valid[g]), .full_o(full[g]), .empty_o(empty[g]),
        .count_o(cnt[g]), .almost_full_o(afull[g]), .almost_empty_o(aempty[g]),
        .overflow_o(ovf_o[g]), .underflow_o(unf_o[g])
      );

      // Reference model: contents as a queue, popped words queued for the monitor
      logic [7:0] mq[$];
      logic [7:0] outq[$];
      logic       ovf, unf, ev;
      logic [7:0] exp_dout;

      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mq.delete();
          outq.delete();
          ovf <= 1'b0; unf <= 1'b0; ev <= 1'b0; exp_dout <= 8'h00;
        end else if (clr[g]) begin
          mq.delete();
          ovf <= 1'b0; unf <= 1'b0; ev <= 1'b0;
        end else begin : step
          automatic int sz;
          sz = mq.size();
          if (wr_en[g] && sz == D) ovf <= 1'b1;
          if (rd_en[g] && sz == 0) unf <= 1'b1;
          ev <= rd_en[g] && sz != 0;
          if (rd_en[g] && sz != 0) begin
            if (FW == 0) begin
              outq.push_back(mq[0]);
              exp_dout <= mq[0];
            end
            void'(mq.pop_front());
          end
          if (wr_en[g] && sz < D) mq.push_back(din[g]);
        end
      end

      always @(negedge clk) begin
        if (checking) begin
          chk("count",   g, cnt[g],    mq.size());
          chk("full",    g, full[g],   mq.size() == D);
          chk("empty",   g, empty[g],  mq.size() == 0);
          chk("afull",   g, afull[g],  mq.size() >= AF);
          chk("aempty",  g, aempty[g], mq.size() <= AE);
          chk("ovf",     g, ovf_o[g],  ovf);
          chk("unf",     g, unf_o[g],  unf);
        end
      end

      if (FW == 0) begin : g_std
        always @(negedge clk) begin
          if (checking) begin
            chk("valid", g, valid[g], ev);
            if (valid[g] && outq.size() != 0) chk("data", g, dout[g], outq.pop_front());
            else if (!valid[g]) chk("hold", g, dout[g], exp_dout);
          end
        end
      end else begin : g_fwft
        always @(negedge clk) begin
          if (checking) begin
            chk("valid", g, valid[g], mq.size() != 0);
            if (valid[g] && mq.size() != 0) chk("head", g, dout[g], mq[0]);
          end
        end
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set(input int l, input bit w, input logic [7:0] d, input bit r, input bit c);
    wr_en[l] = w; din[l] = d; rd_en[l] = r; clr[l] = c;
  endtask

  task automatic idle(input int n);
    set(0, 0, 8'h00, 0, 0);
    set(1, 0, 8'h00, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    set(0, 0, 8'h00, 0, 0);
    set(1, 0, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    chk("rst_empty", 0, empty[0], 1);
    chk("rst_valid", 0, valid[0], 0);
    chk("rst_data",  0, dout[0],  0);
    rst_n = 1'b1;
    idle(1);

    // Fill to full then drain, then read-on-empty and clear
    for (int i = 0; i < 5; i++) begin set(0, 1, 8'h11 + 8'(i), 0, 0); tick(); end
    for (int i = 0; i < 5; i++) begin set(0, 0, 8'h00, 1, 0); tick(); end
    idle(1);
    set(0, 0, 8'h00, 1, 0); tick();
    idle(1);
    set(0, 0, 8'h00, 0, 1); tick();
    idle(1);

    // Full: simultaneous write and read drops the write
    for (int i = 0; i < 5; i++) begin set(0, 1, 8'hA0 + 8'(i), 0, 0); tick(); end
    set(0, 1, 8'hFF, 1, 0); tick();
    idle(1);
    for (int i = 0; i < 4; i++) begin set(0, 0, 8'h00, 1, 0); tick(); end
    set(0, 0, 8'h00, 1, 0); tick();
    set(0, 0, 8'h00, 0, 1); tick();
    idle(1);

    // Wrap: three rounds of three writes and three reads
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin set(0, 1, 8'(r * 3 + k), 0, 0); tick(); end
      for (int k = 0; k < 3; k++) begin set(0, 0, 8'h00, 1, 0); tick(); end
    end
    idle(2);

    // FWFT lane: head visible without read, then pop; then fill for flags
    set(1, 1, 8'h3C, 0, 0); tick();
    idle(2);
    set(1, 0, 8'h00, 1, 0); tick();
    idle(1);
    for (int i = 0; i < 5; i++) begin set(1, 1, 8'h40 + 8'(i), 0, 0); tick(); end
    set(1, 0, 8'h00, 0, 1); tick();
    idle(1);

    // Asynchronous reset in the middle of a clock phase with 3 words stored
    for (int i = 0; i < 3; i++) begin set(0, 1, 8'h60 + 8'(i), 0, 0); tick(); end
    set(0, 0, 8'h00, 1, 0); tick();
    set(0, 1, 8'h63, 0, 0); tick();
    idle(0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_count", 0, cnt[0],   0);
    chk("mrst_empty", 0, empty[0], 1);
    chk("mrst_data",  0, dout[0],  0);
    chk("mrst_valid", 0, valid[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    set(0, 1, 8'h77, 0, 0); tick();
    set(0, 0, 8'h00, 1, 0); tick();
    idle(2);

    // Randomised traffic with drifting write/read bias to visit full and empty
    for (int blk = 0; blk < 15; blk++) begin
      automatic int pw = $urandom_range(15, 85);
      automatic int pr = $urandom_range(15, 85);
      for (int c = 0; c < 200; c++) begin
        for (int l = 0; l < 2; l++) begin
          set(l, $urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
              $urandom_range(0, 99) == 0);
        end
        tick();
      end
    end
    idle(3);
    chk("drain", 0, g_lane[0].outq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
